// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - RV32I instruction decode stage with valid/ready handshake
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   if_valid/if_ready   upstream handshake; if_instr/if_pc offered instruction and address
//   ex_valid/ex_ready   downstream handshake; every ex_* output is registered
//   ex_alu_sel          ALU operation code
//   ex_a_sel, ex_b_sel  operand selects (a: 0=rs1 1=pc, b: 0=rs2 1=imm)
//   ex_imm, ex_pc       immediate operand and pc of the held instruction
//   ex_rs1/rs2/rd       register addresses; ex_reg_wr writes rd
//   ex_illegal          held instruction is an unsupported encoding
//   flush               drop held instruction and refuse the offered one
//   illegal_cnt         saturating count of accepted illegal instructions
module id_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [3:0]  ex_alu_sel,
    output logic        ex_a_sel,
    output logic        ex_b_sel,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_wr,
    output logic        ex_illegal,
    input  logic        flush,
    output logic [15:0] illegal_cnt
);

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
                           ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_SLT = 4'b1000,
                           ALU_SLTU = 4'b1001, ALU_AUIPC = 4'b1010, ALU_LUI = 4'b1011;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011,
                           OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000, F7_ALT = 7'b0100000;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];
    assign imm_i  = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s  = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b  = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                     if_instr[11:8], 1'b0};
    assign imm_j  = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                     if_instr[30:21], 1'b0};

    // funct3 -> ALU op for the base (funct7 = 0) register and immediate forms
    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    logic [3:0]  dec_alu;
    logic        dec_a, dec_b, dec_wr, dec_ill;
    logic [31:0] dec_imm;

    always_comb begin
        dec_alu = ALU_ADD;
        dec_a   = 1'b0;
        dec_b   = 1'b0;
        dec_wr  = 1'b0;
        dec_ill = 1'b0;
        dec_imm = '0;
        case (opcode)
            OP_R: begin
                dec_wr = 1'b1;
                if (funct7 == F7_ZERO)                         dec_alu = base_alu(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000) dec_alu = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101) dec_alu = ALU_SRA;
                else                                           dec_ill = 1'b1;
            end
            OP_I: begin
                dec_b   = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = imm_i;
                dec_alu = base_alu(funct3);
                // Only shifts reuse funct7 as an encoding field; other I-ops treat it as imm.
                if (funct3 == 3'b001 && funct7 != F7_ZERO) dec_ill = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       dec_alu = ALU_SRA;
                    else if (funct7 != F7_ZERO) dec_ill = 1'b1;
                end
            end
            // Upper-immediate ops pass the raw 20-bit field; the ALU applies the <<12.
            OP_LUI: begin
                dec_alu = ALU_LUI;
                dec_b   = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = {12'b0, if_instr[31:12]};
            end
            OP_AUIPC: begin
                dec_alu = ALU_AUIPC;
                dec_a   = 1'b1;
                dec_b   = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = {12'b0, if_instr[31:12]};
            end
            OP_LOAD: begin
                dec_b   = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = imm_i;
                dec_ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_STORE: begin
                dec_b   = 1'b1;
                dec_imm = imm_s;
                dec_ill = funct3[2] || (funct3 == 3'b011);
            end
            OP_BRANCH: begin
                dec_a   = 1'b1;
                dec_b   = 1'b1;
                dec_imm = imm_b;
                dec_ill = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL: begin
                dec_a   = 1'b1;
                dec_b   = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = imm_j;
            end
            OP_JALR: begin
                dec_b   = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = imm_i;
                dec_ill = (funct3 != 3'b000);
            end
            default: dec_ill = 1'b1;
        endcase
    end

    logic        ex_valid_q, ex_valid_d;
    logic [3:0]  alu_q, alu_d;
    logic        a_q, a_d, b_q, b_d, wr_q, wr_d, ill_q, ill_d;
    logic [31:0] imm_q, imm_d, pc_q, pc_d;
    logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [15:0] cnt_q, cnt_d;
    logic        xfer;

    // Gating with rst_n keeps if_ready low for the whole reset window.
    assign if_ready = rst_n && (!ex_valid_q || ex_ready) && !flush;
    assign xfer     = if_valid && if_ready;

    always_comb begin
        ex_valid_d = ex_valid_q;
        alu_d = alu_q;   a_d = a_q;     b_d = b_q;     wr_d = wr_q;   ill_d = ill_q;
        imm_d = imm_q;   pc_d = pc_q;   rs1_d = rs1_q; rs2_d = rs2_q; rd_d = rd_q;
        cnt_d = cnt_q;
        if (flush)         ex_valid_d = 1'b0;
        else if (xfer)     ex_valid_d = 1'b1;
        else if (ex_ready) ex_valid_d = 1'b0;
        if (xfer) begin
            // An illegal decode zeroes every decoded field except the illegal flag.
            alu_d = dec_ill ? ALU_ADD : dec_alu;
            a_d   = dec_a && !dec_ill;
            b_d   = dec_b && !dec_ill;
            wr_d  = dec_wr && !dec_ill && (if_instr[11:7] != 5'd0);
            ill_d = dec_ill;
            imm_d = dec_ill ? 32'd0 : dec_imm;
            rs1_d = dec_ill ? 5'd0 : if_instr[19:15];
            rs2_d = dec_ill ? 5'd0 : if_instr[24:20];
            rd_d  = dec_ill ? 5'd0 : if_instr[11:7];
            pc_d  = if_pc;
            if (dec_ill && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            alu_q <= '0; a_q <= 1'b0; b_q <= 1'b0; wr_q <= 1'b0; ill_q <= 1'b0;
            imm_q <= '0; pc_q <= '0; rs1_q <= '0; rs2_q <= '0; rd_q <= '0;
            cnt_q <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            alu_q <= alu_d; a_q <= a_d; b_q <= b_d; wr_q <= wr_d; ill_q <= ill_d;
            imm_q <= imm_d; pc_q <= pc_d; rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_alu_sel  = alu_q;
    assign ex_a_sel    = a_q;
    assign ex_b_sel    = b_q;
    assign ex_imm      = imm_q;
    assign ex_pc       = pc_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_reg_wr   = wr_q;
    assign ex_illegal  = ill_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - self-checking bench for id_decode_stage
module tb_id_decode_stage;

    typedef struct packed {
        logic [3:0]  alu;
        logic        a;
        logic        b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
    } dec_t;

    typedef struct packed {
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

    logic        clk, rst_n, if_valid, if_ready, ex_valid, ex_ready, flush;
    logic [31:0] if_instr, if_pc, ex_imm, ex_pc;
    logic [3:0]  ex_alu_sel;
    logic        ex_a_sel, ex_b_sel, ex_reg_wr, ex_illegal;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [15:0] illegal_cnt;

    id_decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_sel(ex_alu_sel),
        .ex_a_sel(ex_a_sel), .ex_b_sel(ex_b_sel), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .ex_illegal(ex_illegal), .flush(flush), .illegal_cnt(illegal_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference state: what the stage should be holding.
    logic        m_valid;
    dec_t        m_dec;
    logic [31:0] m_pc;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic dec_t mk(input logic [3:0] alu, input logic a, input logic b,
                                input logic [31:0] imm, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic wr, input logic ill);
        dec_t d;
        d.alu = alu; d.a = a; d.b = b; d.imm = imm;
        d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.wr = wr; d.ill = ill;
        return d;
    endfunction

    function automatic dec_t dut_dec();
        return {ex_alu_sel, ex_a_sel, ex_b_sel, ex_imm, ex_rs1, ex_rs2, ex_rd,
                ex_reg_wr, ex_illegal};
    endfunction

    // ALU code for each funct3 in the plain (funct7 = 0) form.
    function automatic logic [3:0] plain_op(input int f3);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        return tbl[f3];
    endfunction

    // Behavioural decoder: immediates are built as signed integers from field values.
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        int op, f3, f7, ival, sval, bval, jval;
        logic ok;
        op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
        ival = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
        sval = int'(ins[31:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 4096 : 0);
        bval = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048
               - (ins[31] ? 4096 : 0);
        jval = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
               - (ins[31] ? 1048576 : 0);
        d = '0;
        ok = 1'b1;
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7];
        case (op)
            'h33: begin
                d.wr = 1;
                if (f7 == 0) d.alu = plain_op(f3);
                else if (f7 == 'h20 && f3 == 0) d.alu = 4'd1;
                else if (f7 == 'h20 && f3 == 5) d.alu = 4'd7;
                else ok = 0;
            end
            'h13: begin
                d.wr = 1; d.b = 1; d.imm = ival; d.alu = plain_op(f3);
                if (f3 == 1 && f7 != 0) ok = 0;
                if (f3 == 5 && f7 == 'h20) d.alu = 4'd7;
                if (f3 == 5 && f7 != 0 && f7 != 'h20) ok = 0;
            end
            'h37: begin d.alu = 4'd11; d.b = 1; d.wr = 1; d.imm = ins >> 12; end
            'h17: begin d.alu = 4'd10; d.a = 1; d.b = 1; d.wr = 1; d.imm = ins >> 12; end
            'h03: begin d.b = 1; d.wr = 1; d.imm = ival; ok = (f3 inside {0, 1, 2, 4, 5}); end
            'h23: begin d.b = 1; d.imm = sval; ok = (f3 < 3); end
            'h63: begin d.a = 1; d.b = 1; d.imm = bval; ok = !(f3 inside {2, 3}); end
            'h6F: begin d.a = 1; d.b = 1; d.wr = 1; d.imm = jval; end
            'h67: begin d.b = 1; d.wr = 1; d.imm = ival; ok = (f3 == 0); end
            default: ok = 0;
        endcase
        if (!ok) begin
            d = '0;
            d.ill = 1;
        end
        if (d.rd == 0) d.wr = 0;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        case ($urandom_range(0, 10))
            0: r[6:0] = 7'h33;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h37;
            3: r[6:0] = 7'h17;  4: r[6:0] = 7'h03;  5: r[6:0] = 7'h23;
            6: r[6:0] = 7'h63;  7: r[6:0] = 7'h6F;  8: r[6:0] = 7'h67;
            9: r[6:0] = 7'h33;  default: ;
        endcase
        return r;
    endfunction

    // One clock: drive at negedge, check if_ready before the edge, outputs after it.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        logic exp_rdy;
        @(negedge clk);
        if_valid = v; if_instr = ins; if_pc = pc; ex_ready = rdy; flush = fl;
        #1;
        exp_rdy = (!m_valid || rdy) && !fl;
        check("if_ready", 64'(if_ready), 64'(exp_rdy));
        @(posedge clk);
        if (fl) m_valid = 0;
        else if (v && exp_rdy) begin
            m_valid = 1;
            m_dec = ref_decode(ins);
            m_pc = pc;
            if (m_dec.ill && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (rdy) m_valid = 0;
        #1;
        check("ex_valid", 64'(ex_valid), 64'(m_valid));
        check("ex_fields", 64'(dut_dec()), 64'(m_dec));
        check("ex_pc", 64'(ex_pc), 64'(m_pc));
        check("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_fields"}, 64'(dut_dec()), 64'd0);
        check({name, "_pc"}, 64'(ex_pc), 64'd0);
        check({name, "_ctl"}, {46'd0, ex_valid, if_ready, illegal_cnt}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        m_valid = 0; m_dec = '0; m_pc = '0; m_cnt = '0;
        #1 check("if_ready_after_reset", 64'(if_ready), 64'd1);
    endtask

    vec_t vecs [8];

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        ex_ready = 1'b0; flush = 1'b0;
        m_valid = 0; m_dec = '0; m_pc = '0; m_cnt = '0;

        vecs[0] = '{32'h002081B3, mk(4'h0, 0, 0, 32'h0, 5'd1, 5'd2, 5'd3, 1, 0)};
        vecs[1] = '{32'h407302B3, mk(4'h1, 0, 0, 32'h0, 5'd6, 5'd7, 5'd5, 1, 0)};
        vecs[2] = '{32'h4041D113, mk(4'h7, 0, 1, 32'h404, 5'd3, 5'd4, 5'd2, 1, 0)};
        vecs[3] = '{32'h123450B7, mk(4'hB, 0, 1, 32'h12345, 5'd8, 5'd3, 5'd1, 1, 0)};
        vecs[4] = '{32'h00208033, mk(4'h0, 0, 0, 32'h0, 5'd1, 5'd2, 5'd0, 0, 0)};
        vecs[5] = '{32'h008000EF, mk(4'h0, 1, 1, 32'h8, 5'd0, 5'd8, 5'd1, 1, 0)};
        vecs[6] = '{32'hFE20AE23, mk(4'h0, 0, 1, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd28, 0, 0)};
        vecs[7] = '{32'hFFFFFFFF, mk(4'h0, 0, 0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 1)};

        repeat (2) @(posedge clk);
        #1 check_all_zero("reset_init");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("if_ready_first", 64'(if_ready), 64'd1);

        // Directed table, back-to-back with ex_ready held high.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
            check($sformatf("vec%0d", i), 64'(dut_dec()), 64'(vecs[i].exp));
        end

        // Stall: downstream holds off for three cycles while a new instruction waits.
        do_reset();
        cycle(1'b1, 32'h002081B3, 32'h2000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h407302B3, 32'h2004, 1'b0, 1'b0);
            check("stall_hold", 64'(dut_dec()), 64'(vecs[0].exp));
        end
        cycle(1'b1, 32'h407302B3, 32'h2004, 1'b1, 1'b0);
        check("stall_release", 64'(dut_dec()), 64'(vecs[1].exp));

        // Three illegal instructions, then a flush while one is held.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hFFFFFFFF, 32'h3000, 1'b1, 1'b0);
        cycle(1'b1, 32'hFFFFFFFF, 32'h3004, 1'b0, 1'b1);
        check("flush_valid", 64'(ex_valid), 64'd0);
        check("flush_illegal", 64'(ex_illegal), 64'd1);
        check("flush_cnt", 64'(illegal_cnt), 64'd3);

        // Reset asserted in the middle of a stall.
        cycle(1'b1, 32'h002081B3, 32'h4000, 1'b1, 1'b0);
        cycle(1'b1, 32'h407302B3, 32'h4004, 1'b0, 1'b0);
        do_reset();

        // Randomised traffic against the reference model.
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 65540; i++) cycle(1'b1, 32'hFFFFFFFF, 32'h5000, 1'b1, 1'b0);
        check("cnt_saturated", 64'(illegal_cnt), 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_decode_stage.md
ID_DECODE_STAGE -- requirements
Module: id_decode_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset, listed first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
REQ-002 The module SHALL have these upstream (fetch) ports:
- if_valid  in  1  instruction offered
- if_ready  out  1  stage can accept
- if_instr  in  32  RV32I instruction word
- if_pc  in  32  instruction address
REQ-003 The module SHALL have these downstream (execute) ports; all are registered:
- ex_valid  out  1  decoded instruction present
- ex_ready  in  1  execute accepts
- ex_alu_sel  out  4  ALU operation code
- ex_a_sel  out  1  0=rs1, 1=pc
- ex_b_sel  out  1  0=rs2, 1=imm
- ex_imm  out  32  immediate operand
- ex_pc  out  32  pc of held instruction
- ex_rs1  out  5  source register 1 address
- ex_rs2  out  5  source register 2 address
- ex_rd  out  5  destination register address
- ex_reg_wr  out  1  writes rd
- ex_illegal  out  1  unsupported encoding
REQ-004 The module SHALL have these control and status ports:
- flush  in  1  discard held and offered instruction
- illegal_cnt  out  16  saturating count of illegal instructions accepted

Function
REQ-005 ALU operation codes SHALL be: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, AUIPC 1010, LUI 1011.
REQ-006 if_ready SHALL equal (!ex_valid || ex_ready) && !flush.
REQ-007 A transfer SHALL occur when if_valid && if_ready; on that edge all ex_* fields SHALL load the decode of if_instr/if_pc and ex_valid SHALL become 1.
REQ-008 On ex_valid && ex_ready without a new transfer, ex_valid SHALL clear; ex_* fields SHALL hold their values while ex_valid && !ex_ready.
REQ-009 Latency SHALL be one cycle, with back-to-back throughput of one instruction per cycle when ex_ready=1.
REQ-010 flush=1 SHALL clear ex_valid on the next edge, block acceptance that cycle, and take priority over transfer and stall.
REQ-011 The R-type opcode 0110011 SHALL select alu_sel from funct3/funct7, with b_sel=0 and reg_wr=1; funct7 0100000 SHALL select SUB (funct3 000) or SRA (funct3 101).
REQ-012 The I-ALU opcode 0010011 SHALL use b_sel=1 with a sign-extended I immediate; SRAI (funct7 0100000) SHALL give SRA, and funct3 001 with funct7 != 0 SHALL be illegal.
REQ-013 LUI (0110111) and AUIPC (0010111) SHALL give ex_imm = {12'b0, instr[31:20+..12]}, i.e. the unshifted 20-bit field zero-extended, because the ALU applies the <<12.
REQ-014 AUIPC SHALL set a_sel=1.
REQ-015 Address-generating opcodes SHALL use alu_sel ADD with b_sel=1 and these settings:
- loads 0000011: I immediate, reg_wr=1
- stores 0100011: S immediate, reg_wr=0
- branches 1100011: a_sel=1, B immediate, reg_wr=0
- JAL 1101111: a_sel=1, J immediate, reg_wr=1
- JALR 1100111: I immediate, reg_wr=1
REQ-016 Any other opcode or invalid funct SHALL produce ex_illegal=1, alu_sel=0000, reg_wr=0, and all other fields decoded as the don't-care default 0.
REQ-017 rd=0 SHALL force ex_reg_wr=0.
REQ-018 illegal_cnt SHALL increment on each transfer with an illegal decode, saturate at 0xFFFF, and not count flushed-cycle instructions.

Reset
REQ-019 While rst_n=0, outputs SHALL asynchronously clear: ex_valid=0, every ex_* field=0, illegal_cnt=0. if_ready SHALL be 0 during reset and 1 on the first cycle after deassertion when flush=0.
REQ-020 Reset asserted mid-stall SHALL discard the held instruction without a transfer.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- 0x002081B3 (add x3,x1,x2) -> alu_sel=0000, rs1=1, rs2=2, rd=3, b_sel=0, reg_wr=1, one cycle later.
- 0x407302B3 (sub x5,x6,x7) -> alu_sel=0001; 0x4041D113 (srai x2,x3,4) -> alu_sel=0111, b_sel=1, imm=0x00000404.
- 0x123450B7 (lui x1,0x12345) -> alu_sel=1011, imm=0x00012345, b_sel=1, a_sel=0, rd=1.
- Hold ex_ready=0 for 3 cycles with if_valid=1 -> if_ready=0 and ex_* stable; release -> next instruction loads on the following edge.
- 0xFFFFFFFF sent 3 times, then flush with ex_valid=1 -> ex_illegal=1, illegal_cnt=3, ex_valid=0 after flush edge; rst_n pulse mid-stall -> all outputs 0.
